// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory port arbiter.
// State and requester encodings are used by the arbiter FSM and the picker.
// Default widths match a 32-bit core memory port.
package mem_arb_pkg;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      BUSY_INST = 2'd1,
      BUSY_DATA = 2'd2
   } arb_state_t;

   typedef enum logic {
      REQ_INST = 1'b0,
      REQ_DATA = 1'b1
   } requester_t;

endpackage

// File: rtl/arb_pick.sv
// Two-way grant picker for the memory port arbiter (macro ARB_ROUND_ROBIN_EN).
// Latency: purely combinational, no state.
// Backpressure: none; the caller only consults the result while idle.
module arb_pick
   import mem_arb_pkg::*;
(
   input  logic inst_valid,
   input  logic data_valid,
   input  logic last_grant,   // requester_t encoding of the previous winner
   output logic grant,        // requester_t encoding of the winner
   output logic grant_valid
);

`ifdef ARB_ROUND_ROBIN_EN
   // On a tie, alternate away from whoever won last
   always_comb begin
      grant_valid = inst_valid | data_valid;
      grant       = REQ_DATA;
      if (inst_valid && !data_valid) begin
         grant = REQ_INST;
      end else if (inst_valid && data_valid) begin
         grant = (last_grant == REQ_DATA) ? REQ_INST : REQ_DATA;
      end
   end
`else
   // Fixed priority: data wins every tie, so fetch can starve under constant data traffic
   always_comb begin
      grant_valid = inst_valid | data_valid;
      grant       = REQ_DATA;
      if (inst_valid && !data_valid) begin
         grant = REQ_INST;
      end
   end

   // History input is kept on the port so both builds share one interface
   logic unused_last_grant;
   assign unused_last_grant = last_grant;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and load/store requesters; tie rule set by ARB_ROUND_ROBIN_EN.
// Latency: grant registered at the request edge, response ready/data passed straight through from memory.
// Backpressure: requesters hold valid until their one-cycle ready; one idle cycle separates grants.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] inst_req_addr,
   input  logic              inst_req_valid,
   output logic [DATA_W-1:0] inst_req_data,
   output logic              inst_req_ready,
   input  logic [ADDR_W-1:0] data_req_addr,
   input  logic [DATA_W-1:0] data_req_wdata,
   input  logic              data_req_write,
   input  logic              data_req_valid,
   output logic [DATA_W-1:0] data_req_rdata,
   output logic              data_req_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_write,
   output logic              mem_valid,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              busy
);

   arb_state_t state;
   requester_t last_grant;
   logic       pick_grant;
   logic       pick_valid;

   arb_pick u_pick (
      .inst_valid  (inst_req_valid),
      .data_valid  (data_req_valid),
      .last_grant  (last_grant),
      .grant       (pick_grant),
      .grant_valid (pick_valid)
   );

   // Grant FSM: latch the winner's request into the memory port, release on mem_ready
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= REQ_DATA;
         mem_valid  <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_write  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  mem_valid <= 1'b1;
                  if (pick_grant == REQ_INST) begin
                     mem_addr  <= inst_req_addr;
                     mem_wdata <= '0;
                     mem_write <= 1'b0;
                     state     <= BUSY_INST;
                  end else begin
                     mem_addr  <= data_req_addr;
                     mem_wdata <= data_req_wdata;
                     mem_write <= data_req_write;
                     state     <= BUSY_DATA;
                  end
               end
            end
            BUSY_INST: begin
               if (mem_ready) begin
                  state      <= IDLE;
                  mem_valid  <= 1'b0;
                  last_grant <= REQ_INST;
               end
            end
            BUSY_DATA: begin
               if (mem_ready) begin
                  state      <= IDLE;
                  mem_valid  <= 1'b0;
                  last_grant <= REQ_DATA;
               end
            end
            default: begin
               state     <= IDLE;
               mem_valid <= 1'b0;
            end
         endcase
      end
   end

   // Response path: read data is shared, only the owner of the transaction sees ready
   always_comb begin
      inst_req_data  = mem_rdata;
      data_req_rdata = mem_rdata;
      inst_req_ready = (state == BUSY_INST) && mem_ready;
      data_req_ready = (state == BUSY_DATA) && mem_ready;
      busy           = (state != IDLE);
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model of the arbitration rules.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] inst_req_addr;
   logic        inst_req_valid;
   logic [31:0] inst_req_data;
   logic        inst_req_ready;
   logic [31:0] data_req_addr;
   logic [31:0] data_req_wdata;
   logic        data_req_write;
   logic        data_req_valid;
   logic [31:0] data_req_rdata;
   logic        data_req_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_write;
   logic        mem_valid;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        busy;

   int checks = 0;
   int errors = 0;

   mem_port_arbiter dut (
      .clk            (clk),
      .reset          (reset),
      .inst_req_addr  (inst_req_addr),
      .inst_req_valid (inst_req_valid),
      .inst_req_data  (inst_req_data),
      .inst_req_ready (inst_req_ready),
      .data_req_addr  (data_req_addr),
      .data_req_wdata (data_req_wdata),
      .data_req_write (data_req_write),
      .data_req_valid (data_req_valid),
      .data_req_rdata (data_req_rdata),
      .data_req_ready (data_req_ready),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_write      (mem_write),
      .mem_valid      (mem_valid),
      .mem_rdata      (mem_rdata),
      .mem_ready      (mem_ready),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   // Advance to just after the next rising edge; inputs change here, checks follow a #1 later
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      inst_req_addr  = '0;
      inst_req_valid = 1'b0;
      data_req_addr  = '0;
      data_req_wdata = '0;
      data_req_write = 1'b0;
      data_req_valid = 1'b0;
      mem_rdata      = '0;
      mem_ready      = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL reset_mem_valid got %b want 0", mem_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
      checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata got %h want 0", mem_wdata); end
      checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL reset_mem_write got %b want 0", mem_write); end
      checks++; if ({inst_req_ready, data_req_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got %b want 00", {inst_req_ready, data_req_ready}); end
   endtask

   task automatic test_inst_fetch();
      int pulses = 0;
      do_reset();
      inst_req_valid = 1'b1;
      inst_req_addr  = 32'h100;
      step();                          // grant edge t has passed
      #1;
      checks++; if (mem_valid !== 1'b1 || mem_addr !== 32'h100 || mem_write !== 1'b0) begin
         errors++; $display("FAIL fetch_issue got valid=%b addr=%h wr=%b want 1/100/0", mem_valid, mem_addr, mem_write); end
      if (inst_req_ready) pulses++;
      step();                          // second busy cycle, memory responds
      mem_ready = 1'b1;
      mem_rdata = 32'hDEADBEEF;
      #1;
      checks++; if (inst_req_ready !== 1'b1 || inst_req_data !== 32'hDEADBEEF) begin
         errors++; $display("FAIL fetch_resp got rdy=%b data=%h want 1/deadbeef", inst_req_ready, inst_req_data); end
      checks++; if (data_req_ready !== 1'b0) begin errors++; $display("FAIL fetch_data_rdy got %b want 0", data_req_ready); end
      if (inst_req_ready) pulses++;
      step();
      inst_req_valid = 1'b0;
      mem_ready      = 1'b0;
      #1;
      if (inst_req_ready) pulses++;
      checks++; if (mem_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL fetch_release got valid=%b busy=%b want 0/0", mem_valid, busy); end
      step();
      #1;
      if (inst_req_ready) pulses++;
      checks++; if (pulses != 1) begin errors++; $display("FAIL fetch_pulse_count got %0d want 1", pulses); end
   endtask

   task automatic test_store();
      do_reset();
      data_req_valid = 1'b1;
      data_req_write = 1'b1;
      data_req_addr  = 32'h40;
      data_req_wdata = 32'h12345678;
      step();
      #1;
      checks++; if (mem_write !== 1'b1 || mem_wdata !== 32'h12345678 || mem_addr !== 32'h40) begin
         errors++; $display("FAIL store_issue got wr=%b wdata=%h addr=%h want 1/12345678/40", mem_write, mem_wdata, mem_addr); end
      data_req_addr  = 32'h99;
      data_req_wdata = 32'hFFFF0000;
      step();
      #1;
      checks++; if (mem_addr !== 32'h40 || mem_wdata !== 32'h12345678 || mem_valid !== 1'b1) begin
         errors++; $display("FAIL store_hold got addr=%h wdata=%h valid=%b want 40/12345678/1", mem_addr, mem_wdata, mem_valid); end
      mem_ready = 1'b1;
      mem_rdata = 32'h0BADF00D;
      #1;
      checks++; if (data_req_ready !== 1'b1 || inst_req_ready !== 1'b0 || data_req_rdata !== 32'h0BADF00D) begin
         errors++; $display("FAIL store_resp got drdy=%b irdy=%b rdata=%h want 1/0/0badf00d", data_req_ready, inst_req_ready, data_req_rdata); end
      step();
      clear_inputs();
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL store_release got busy=%b want 0", busy); end
   endtask

   task automatic test_tie();
      logic exp_inst [3];
      int   inst_pulses = 0;
      int   exp_pulses  = 0;
`ifdef ARB_ROUND_ROBIN_EN
      exp_inst[0] = 1'b1; exp_inst[1] = 1'b0; exp_inst[2] = 1'b1;
`else
      exp_inst[0] = 1'b0; exp_inst[1] = 1'b0; exp_inst[2] = 1'b0;
`endif
      do_reset();
      inst_req_valid = 1'b1;
      inst_req_addr  = 32'hA0;
      data_req_valid = 1'b1;
      data_req_addr  = 32'hD0;
      for (int k = 0; k < 3; k++) begin
         if (exp_inst[k]) exp_pulses++;
         step();
         #1;
         checks++; if (mem_valid !== 1'b1 || mem_addr !== (exp_inst[k] ? 32'hA0 : 32'hD0)) begin
            errors++; $display("FAIL tie_grant%0d got valid=%b addr=%h want inst=%b", k, mem_valid, mem_addr, exp_inst[k]); end
         mem_ready = 1'b1;
         mem_rdata = 32'(k);
         #1;
         checks++; if (inst_req_ready !== exp_inst[k] || data_req_ready !== !exp_inst[k]) begin
            errors++; $display("FAIL tie_ready%0d got i=%b d=%b want i=%b", k, inst_req_ready, data_req_ready, exp_inst[k]); end
         if (inst_req_ready) inst_pulses++;
         step();
         mem_ready = 1'b0;
         #1;
         if (inst_req_ready) inst_pulses++;
      end
      clear_inputs();
      step();
      checks++; if (inst_pulses != exp_pulses) begin
         errors++; $display("FAIL tie_inst_pulses got %0d want %0d", inst_pulses, exp_pulses); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      data_req_valid = 1'b1;
      data_req_write = 1'b1;
      data_req_addr  = 32'h55;
      data_req_wdata = 32'h66;
      step();
      #1;
      checks++; if (busy !== 1'b1 || mem_valid !== 1'b1) begin
         errors++; $display("FAIL midrst_busy got busy=%b valid=%b want 1/1", busy, mem_valid); end
      data_req_valid = 1'b0;
      reset = 1'b1;
      step();
      reset     = 1'b0;
      mem_ready = 1'b1;
      mem_rdata = 32'h77;
      #1;
      checks++; if ({inst_req_ready, data_req_ready} !== 2'b00 || mem_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL midrst_after got rdy=%b%b valid=%b busy=%b want 00/0/0", inst_req_ready, data_req_ready, mem_valid, busy); end
      step();
      mem_ready = 1'b0;
      #1;
      checks++; if (mem_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL midrst_idle got valid=%b busy=%b want 0/0", mem_valid, busy); end
   endtask

   task automatic test_idle_ready();
      do_reset();
      for (int k = 0; k < 3; k++) begin
         mem_ready = 1'b1;
         mem_rdata = $urandom;
         #1;
         checks++; if ({inst_req_ready, data_req_ready} !== 2'b00 || busy !== 1'b0 || mem_valid !== 1'b0) begin
            errors++; $display("FAIL idle_ready%0d got rdy=%b%b busy=%b valid=%b want 00/0/0", k, inst_req_ready, data_req_ready, busy, mem_valid); end
         step();
      end
      mem_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      do_reset();
      inst_req_valid = 1'b1;
      inst_req_addr  = 32'h200;
      step();
      mem_ready = 1'b1;                // earliest possible response, cycle r
      mem_rdata = 32'h11;
      #1;
      checks++; if (inst_req_ready !== 1'b1) begin errors++; $display("FAIL b2b_first got %b want 1", inst_req_ready); end
      step();                          // cycle r+1: idle, valid still held
      mem_ready     = 1'b0;
      inst_req_addr = 32'h204;
      #1;
      checks++; if (mem_valid !== 1'b0 || busy !== 1'b0 || inst_req_ready !== 1'b0) begin
         errors++; $display("FAIL b2b_gap got valid=%b busy=%b rdy=%b want 0/0/0", mem_valid, busy, inst_req_ready); end
      step();                          // cycle r+2: second grant visible
      inst_req_valid = 1'b0;
      #1;
      checks++; if (mem_valid !== 1'b1 || mem_addr !== 32'h204) begin
         errors++; $display("FAIL b2b_second got valid=%b addr=%h want 1/204", mem_valid, mem_addr); end
      mem_ready = 1'b1;
      mem_rdata = 32'h22;
      #1;
      checks++; if (inst_req_ready !== 1'b1 || inst_req_data !== 32'h22) begin
         errors++; $display("FAIL b2b_second_resp got rdy=%b data=%h want 1/22", inst_req_ready, inst_req_data); end
      step();
      clear_inputs();
   endtask

   // Randomized traffic: the model tracks which requester owns the outstanding
   // memory transaction and what it asked for, and applies the tie rule directly.
   task automatic test_random();
      int          owner;              // 0 = none, 1 = inst, 2 = data
      int          last;               // 1 = inst, 2 = data
      logic [31:0] m_addr;
      logic [31:0] m_wdata;
      logic        m_write;
      logic        inst_done;
      logic        data_done;
      logic        e_irdy;
      logic        e_drdy;
      do_reset();
      owner = 0; last = 2; inst_done = 1'b0; data_done = 1'b0;
      m_addr = '0; m_wdata = '0; m_write = 1'b0;
      for (int c = 0; c < 800; c++) begin
         inst_req_addr  = $urandom;
         data_req_addr  = $urandom;
         data_req_wdata = $urandom;
         data_req_write = 1'($urandom_range(0, 1));
         if (!inst_req_valid) inst_req_valid = ($urandom_range(0, 2) == 0);
         else if (inst_done)  inst_req_valid = 1'($urandom_range(0, 1));
         if (!data_req_valid) data_req_valid = ($urandom_range(0, 2) == 0);
         else if (data_done)  data_req_valid = 1'($urandom_range(0, 1));
         mem_ready = ($urandom_range(0, 9) < 4);
         mem_rdata = $urandom;
         #1;
         e_irdy = (owner == 1) && mem_ready;
         e_drdy = (owner == 2) && mem_ready;
         checks++; if (inst_req_ready !== e_irdy || data_req_ready !== e_drdy) begin
            errors++; $display("FAIL rand_ready c=%0d got i=%b d=%b want i=%b d=%b", c, inst_req_ready, data_req_ready, e_irdy, e_drdy); end
         checks++; if (mem_valid !== (owner != 0) || busy !== (owner != 0)) begin
            errors++; $display("FAIL rand_busy c=%0d got valid=%b busy=%b want %b", c, mem_valid, busy, owner != 0); end
         checks++; if (inst_req_data !== mem_rdata || data_req_rdata !== mem_rdata) begin
            errors++; $display("FAIL rand_rdata c=%0d got %h/%h want %h", c, inst_req_data, data_req_rdata, mem_rdata); end
         if (owner != 0) begin
            checks++; if (mem_addr !== m_addr || mem_write !== m_write || (m_write && mem_wdata !== m_wdata)) begin
               errors++; $display("FAIL rand_port c=%0d got addr=%h wr=%b wdata=%h want %h/%b/%h", c, mem_addr, mem_write, mem_wdata, m_addr, m_write, m_wdata); end
         end
         inst_done = e_irdy;
         data_done = e_drdy;
         // Reference update for the coming edge
         if (owner == 0) begin
            if (inst_req_valid && data_req_valid) begin
`ifdef ARB_ROUND_ROBIN_EN
               owner = (last == 2) ? 1 : 2;
`else
               owner = 2;
`endif
            end else if (inst_req_valid) begin
               owner = 1;
            end else if (data_req_valid) begin
               owner = 2;
            end
            if (owner == 1) begin
               m_addr = inst_req_addr; m_write = 1'b0; m_wdata = '0;
            end else if (owner == 2) begin
               m_addr = data_req_addr; m_write = data_req_write; m_wdata = data_req_wdata;
            end
         end else if (mem_ready) begin
            last  = owner;
            owner = 0;
         end
         step();
      end
      clear_inputs();
   endtask

   initial begin
      reset = 1'b1;
      clear_inputs();
      test_reset();
      test_inst_fetch();
      test_store();
      test_tie();
      test_reset_mid();
      test_idle_ready();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port memory between the instruction fetch requester and the data (load/store) requester.
- Both requesters use the team's valid/ready memory handshake: hold valid, wait for a one-cycle ready pulse carrying read data.
- Sits between the fetch/execute units and the memory controller.
- Latches the winning request, drives the memory port, and routes the response back to the granted requester only.

Parameters:
ADDR_W, 32, address width for both requesters and the memory port
DATA_W, 32, data width for read and write data

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
inst_req_addr  in  ADDR_W  fetch address
inst_req_valid  in  1  fetch request pending
inst_req_data  out  DATA_W  fetched word, valid when inst_req_ready=1
inst_req_ready  out  1  one-cycle completion pulse to the fetcher
data_req_addr  in  ADDR_W  load/store address
data_req_wdata  in  DATA_W  store data
data_req_write  in  1  1=store, 0=load
data_req_valid  in  1  data request pending
data_req_rdata  out  DATA_W  load result, valid when data_req_ready=1
data_req_ready  out  1  one-cycle completion pulse to the data requester
mem_addr  out  ADDR_W  registered memory address
mem_wdata  out  DATA_W  registered store data
mem_write  out  1  registered write enable
mem_valid  out  1  registered memory request valid
mem_rdata  in  DATA_W  memory read data
mem_ready  in  1  memory completion pulse
busy  out  1  high while state is not IDLE

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- FSM states: IDLE, BUSY_INST, BUSY_DATA. Reset sets state=IDLE and mem_valid=0.
- Reset values: mem_addr=0, mem_wdata=0, mem_write=0, busy=0, last_grant=DATA.
- Requester ready pulses are combinational; they are 0 whenever state is IDLE.
- IDLE, exactly one requester valid at edge t:
  - Latch that requester's addr, wdata and write into mem_* (inst requests force mem_write=0).
  - Set mem_valid=1 and move to BUSY_INST or BUSY_DATA.
  - mem_valid is therefore first visible in cycle t+1.
- IDLE, both requesters valid: resolve per the tie rule (see Optional Feature); the loser stays pending untouched.
- IDLE, neither requester valid: stay in IDLE.
- BUSY_x, mem_ready=1 in cycle u:
  - Same cycle: x_req_ready=1, and the read data output equals mem_rdata. This is a pass-through; zero added response latency.
  - The non-granted ready stays 0.
  - At edge u: state=IDLE, mem_valid=0, last_grant=x.
- BUSY_x, mem_ready=0: hold all mem_* outputs stable. Requester inputs are ignored because they were latched at grant.
- Minimum transaction: request sampled at t, mem_ready no earlier than t+1, so ready at t+1 at the earliest. One dead IDLE cycle separates consecutive grants.
- A requester still asserting valid in the IDLE cycle after its ready pulse is treated as a new request. The fetcher deasserts valid the cycle after ready.
- mem_ready while IDLE: ignored, no ready pulse emitted.
- Reset mid-transaction: state returns to IDLE and mem_valid=0 the next cycle. Any later mem_ready for the aborted request is ignored (it arrives in IDLE).
- Data outputs (inst_req_data, data_req_rdata) may be driven from mem_rdata at all times; only the ready pulses are qualified.

Optional Feature:
Macro ARB_ROUND_ROBIN_EN.
- Defined: on a tie in IDLE, grant the requester not equal to last_grant. Because reset sets last_grant=DATA, the first tie goes to inst.
- Undefined: fixed priority, data always wins ties. last_grant is still kept but unused, and inst can be starved by back-to-back data requests.

Decomposition:
- Shared package mem_arb_pkg holds:
  - enum arb_state_t {IDLE, BUSY_INST, BUSY_DATA}
  - enum requester_t {REQ_INST, REQ_DATA}
  - localparams for default ADDR_W/DATA_W
- The grant-selection logic is a natural small sub-module, arb_pick: a combinational 2-way picker taking both valids and last_grant, returning a grant and a grant-valid flag. The macro is confined to arb_pick.
- FSM and port registers stay in mem_port_arbiter.

Test Plan:
- Reset, then inst_req_valid=1, addr=0x100; mem_ready=1 with rdata=0xDEADBEEF 2 cycles after grant -> mem_valid rises t+1 with mem_addr=0x100, mem_write=0; inst_req_ready pulses exactly once with data 0xDEADBEEF; data_req_ready stays 0.
- Store: data_req_valid=1, write=1, addr=0x40, wdata=0x12345678 -> mem_write=1, mem_wdata=0x12345678; requester changes addr to 0x99 mid-busy and mem_addr stays 0x40; data_req_ready pulses on mem_ready.
- Both valid in the same IDLE cycle, three back-to-back transactions -> with ARB_ROUND_ROBIN_EN the grants go inst, data, inst; without it they go data, data, data, and inst_req_ready stays 0.
- Reset asserted while in BUSY_DATA, then mem_ready=1 the cycle after reset releases -> state IDLE, mem_valid=0, no ready pulse to either requester.
- mem_ready=1 while IDLE, no requests -> no ready pulses, busy stays 0, mem_valid stays 0.
- Requester holds valid one extra cycle after ready -> second grant begins in the IDLE cycle, and mem_valid reasserts exactly 2 cycles after the first ready.
